tx_escaper_sched: RTL

Transmit-side scheduler that shares the escaper input between two `tx_fifo_stage`-style requesters (data lane, control lane) and periodically inserts clock-compensation (CC) words. It offers the single escaper slot to one lane at a time through that lane's `idle` input, registers the granted word, and presents it to the escaper with the same `en`/`idle` handshake. The block sits between the two fifo stages and the escaper, in the `in_enable` domain.

---
 rtl/tx_escaper_sched.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/tx_escaper_sched.sv
// tx_escaper_sched: shares the single escaper input slot between a data lane
// and a control lane, and periodically inserts clock-compensation (CC) words.
// The granted word is registered once and presented to the escaper with the
// same en/idle handshake that the lanes use towards this block.
module tx_escaper_sched #(
  parameter int unsigned          WR_WIDTH  = 12,
  parameter int unsigned          CC_PERIOD = 1024,
  parameter int unsigned          CC_LEN    = 2,
  parameter logic [WR_WIDTH-1:0]  CC_WORD   = WR_WIDTH'(12'hF7C),
  parameter int unsigned          MAX_BURST = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_enable,
  input  logic                dat_en,
  input  logic [WR_WIDTH-1:0] dat_data,
  output logic                dat_idle,
  input  logic                ctl_en,
  input  logic [WR_WIDTH-1:0] ctl_data,
  output logic                ctl_idle,
  output logic                out_en,
  output logic [WR_WIDTH-1:0] out_data,
  input  logic                in_idle,
  output logic                cc_active
);

  localparam int unsigned PER_W = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(CC_PERIOD - 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CC_LAST    = CNT_W'(CC_LEN - 1);

  localparam logic PTR_DAT = 1'b0;
  localparam logic PTR_CTL = 1'b1;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_CC_INS = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_vld;
  logic [WR_WIDTH-1:0]   r_data;
  logic                  r_ptr;
  logic [CNT_W-1:0]      r_burst;
  logic [PER_W-1:0]      r_per_cnt;
  logic [CNT_W-1:0]      r_cc_cnt;

  logic                  w_slot_free;
  logic                  w_xfer;
  logic                  w_offer;
  logic                  w_accept;
  logic                  w_cc_load;
  logic [WR_WIDTH-1:0]   w_lane_data;

  // The output register can take a new word when empty or draining this cycle.
  assign w_slot_free = !r_vld || in_idle;
  assign w_xfer      = r_vld && in_idle && in_enable;

  assign out_en   = r_vld && in_idle;
  assign out_data = r_data;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: enter CC after the period expires, leave after the last CC load.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL: begin
        if (in_enable && (r_per_cnt == PER_LAST)) begin
          w_state_nxt = ST_CC_INS;
        end
      end
      ST_CC_INS: begin
        if (in_enable && w_slot_free && (r_cc_cnt == CC_LAST)) begin
          w_state_nxt = ST_NORMAL;
        end
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  // Outputs and strobes: lane offer/accept in NORMAL, CC loads in CC_INS.
  always_comb begin
    w_offer     = 1'b0;
    w_accept    = 1'b0;
    w_cc_load   = 1'b0;
    w_lane_data = dat_data;
    dat_idle    = 1'b0;
    ctl_idle    = 1'b0;
    cc_active   = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        // Reset gating keeps both lane idles low while reset is held.
        w_offer     = w_slot_free && in_enable && !reset;
        dat_idle    = w_offer && (r_ptr == PTR_DAT);
        ctl_idle    = w_offer && (r_ptr == PTR_CTL);
        w_accept    = (dat_idle && dat_en) || (ctl_idle && ctl_en);
        w_lane_data = (r_ptr == PTR_CTL) ? ctl_data : dat_data;
      end
      ST_CC_INS: begin
        cc_active = 1'b1;
        w_cc_load = w_slot_free && in_enable;
      end
      default: begin
        cc_active = 1'b0;
      end
    endcase
  end

  // Output word register: a new load wins over a simultaneous drain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vld  <= 1'b0;
      r_data <= '0;
    end else if (w_accept) begin
      r_vld  <= 1'b1;
      r_data <= w_lane_data;
    end else if (w_cc_load) begin
      r_vld  <= 1'b1;
      r_data <= CC_WORD;
    end else if (w_xfer) begin
      r_vld  <= 1'b0;
    end
  end

  // Lane pointer: switch after a full burst or after a declined offer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr   <= PTR_DAT;
      r_burst <= '0;
    end else if (w_accept) begin
      if (r_burst == BURST_LAST) begin
        r_ptr   <= ~r_ptr;
        r_burst <= '0;
      end else begin
        r_burst <= r_burst + CNT_W'(1);
      end
    end else if (w_offer) begin
      r_ptr   <= ~r_ptr;
      r_burst <= '0;
    end
  end

  // CC period counter: counts enabled NORMAL cycles, held at zero during CC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_per_cnt <= '0;
    end else if (in_enable && (r_state == ST_NORMAL)) begin
      if (r_per_cnt == PER_LAST) begin
        r_per_cnt <= '0;
      end else begin
        r_per_cnt <= r_per_cnt + PER_W'(1);
      end
    end
  end

  // CC word counter within one insertion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cc_cnt <= '0;
    end else if (w_cc_load) begin
      if (r_cc_cnt == CC_LAST) begin
        r_cc_cnt <= '0;
      end else begin
        r_cc_cnt <= r_cc_cnt + CNT_W'(1);
      end
    end
  end

endmodule
